// File: rtl/sar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sar_sequencer
// Brief    : Multi-channel SAR ADC scan sequencer (clear, settle, convert,
//            capture per enabled channel). Optional macro SAR_SEQ_TIMEOUT_EN
//            adds a conversion watchdog with a sticky timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module sar_sequencer #(
    parameter int NCH         = 4,
    parameter int DATA_W      = 10,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   run_conversion,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   cont_mode,
    input  logic                   adc_done,
    input  logic [DATA_W-1:0]      adc_data,
    output logic                   clk_dff,
    output logic                   clk_pga,
    output logic                   adc_resetb,
    output logic                   adc_convert,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   result_valid,
    output logic [DATA_W-1:0]      result_data,
    output logic [$clog2(NCH)-1:0] result_ch,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int         c_ch_w        = $clog2(NCH);
    localparam logic [7:0] c_settle_load = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        SETTLE     = 3'd2,
        CONVERTING = 3'd3,
        CAPTURE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NCH-1:0]      r_shadow;
    logic [NCH-1:0]      w_shadow_nxt;
    logic [c_ch_w-1:0]   r_ch_sel;
    logic [c_ch_w-1:0]   w_ch_sel_nxt;
    logic [7:0]          r_settle_cnt;
    logic [7:0]          w_settle_nxt;
    logic [DATA_W-1:0]   r_result_data;
    logic [DATA_W-1:0]   w_result_data_nxt;
    logic [c_ch_w-1:0]   r_result_ch;
    logic [c_ch_w-1:0]   w_result_ch_nxt;

    logic [c_ch_w-1:0]   w_mask_low;
    logic [c_ch_w-1:0]   w_shadow_low;
    logic                w_up_found;
    logic [c_ch_w-1:0]   w_up_idx;
    logic                w_advance;
    logic                w_tmo_hit;

    // Descending scan so the last hit is the lowest qualifying channel.
    always_comb begin
        w_mask_low   = '0;
        w_shadow_low = '0;
        w_up_found   = 1'b0;
        w_up_idx     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_mask_low = c_ch_w'(i);
            end
            if (r_shadow[i]) begin
                w_shadow_low = c_ch_w'(i);
            end
            if (r_shadow[i] && (i > int'(r_ch_sel))) begin
                w_up_found = 1'b1;
                w_up_idx   = c_ch_w'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shadow_nxt      = r_shadow;
        w_ch_sel_nxt      = r_ch_sel;
        w_settle_nxt      = r_settle_cnt;
        w_result_data_nxt = r_result_data;
        w_result_ch_nxt   = r_result_ch;
        w_advance         = 1'b0;

        case (r_state)
            IDLE: begin
                if (run_conversion && (|ch_mask)) begin
                    w_shadow_nxt = ch_mask;
                    w_ch_sel_nxt = w_mask_low;
                    w_state_nxt  = CLEAR;
                end
            end
            CLEAR: begin
                if (!run_conversion) begin
                    w_state_nxt = IDLE;
                end else if (SETTLE_CYC == 0) begin
                    w_state_nxt = CONVERTING;
                end else begin
                    w_settle_nxt = c_settle_load;
                    w_state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (!run_conversion) begin
                    w_state_nxt = IDLE;
                end else if (r_settle_cnt == 8'd0) begin
                    w_state_nxt = CONVERTING;
                end else begin
                    w_settle_nxt = r_settle_cnt - 8'd1;
                end
            end
            CONVERTING: begin
                // Abort wins over a simultaneous adc_done.
                if (!run_conversion) begin
                    w_state_nxt = IDLE;
                end else if (adc_done) begin
                    w_result_data_nxt = adc_data;
                    w_result_ch_nxt   = r_ch_sel;
                    w_state_nxt       = CAPTURE;
                end else if (w_tmo_hit) begin
                    w_advance = 1'b1;
                end
            end
            CAPTURE: begin
                if (!run_conversion) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Step to the next enabled channel; at the end of the list either
        // re-latch the live mask and rescan, or return to idle.
        if (w_advance) begin
            if (w_up_found) begin
                w_ch_sel_nxt = w_up_idx;
                w_state_nxt  = CLEAR;
            end else if (cont_mode && (|ch_mask)) begin
                w_shadow_nxt = ch_mask;
                w_ch_sel_nxt = w_mask_low;
                w_state_nxt  = CLEAR;
            end else begin
                w_ch_sel_nxt = w_shadow_low;
                w_state_nxt  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state       <= IDLE;
            r_shadow      <= '0;
            r_ch_sel      <= '0;
            r_settle_cnt  <= '0;
            r_result_data <= '0;
            r_result_ch   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shadow      <= w_shadow_nxt;
            r_ch_sel      <= w_ch_sel_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_result_data <= w_result_data_nxt;
            r_result_ch   <= w_result_ch_nxt;
        end
    end

`ifdef SAR_SEQ_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_timeout_err;

    // Counts completed CONVERTING cycles; hit marks the last allowed one.
    assign w_tmo_hit = (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == CONVERTING) && (w_state_nxt == CONVERTING)) begin
                r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if ((r_state == IDLE) && (w_state_nxt == CLEAR)) begin
                r_timeout_err <= 1'b0;
            end else if ((r_state == CONVERTING) && w_tmo_hit && run_conversion && !adc_done) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_tmo_cfg;

    assign w_tmo_hit        = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_tmo_cfg = (TIMEOUT_CYC == 0);
`endif

    assign adc_resetb   = (r_state != CLEAR);
    assign clk_pga      = (r_state != CLEAR);
    assign adc_convert  = (r_state == CONVERTING);
    assign result_valid = (r_state == CAPTURE);
    assign busy         = (r_state != IDLE);
    assign clk_dff      = clk & adc_convert;
    assign ch_sel       = r_ch_sel;
    assign result_data  = r_result_data;
    assign result_ch    = r_result_ch;

endmodule
`default_nettype wire
